// File: rtl/control_unit.sv
// control_unit: multicycle FETCH/DECODE/EXECUTE controller for the 11-bit accumulator datapath.
// Optional macro CTRL_EXT_BRANCH_EN enables BGT/BGE/BLT/BLE; otherwise they decode as NOP.
module control_unit #(
  parameter int DATA_WIDTH   = 11,
  parameter int OPCODE_WIDTH = 5
) (
  input  logic                               clock_in,
  input  logic                               reset_n_in,
  input  logic [OPCODE_WIDTH+DATA_WIDTH-1:0] instruction_in,
  input  logic                               flag_Z_in,
  input  logic                               flag_N_in,
  output logic [DATA_WIDTH-1:0]              program_memory_address_out,
  output logic [DATA_WIDTH-1:0]              operand_out,
  output logic                               op_alu_out,
  output logic [1:0]                         sel_A_out,
  output logic                               sel_B_out,
  output logic                               acc_wr_out,
  output logic                               acc_reset_out,
  output logic                               status_wr_out,
  output logic                               status_reset_out,
  output logic                               data_memory_wr_out,
  output logic                               halted_out
);

  localparam int IW = OPCODE_WIDTH + DATA_WIDTH;

  typedef logic [OPCODE_WIDTH-1:0] op_t;

  localparam op_t OP_HLT  = op_t'(0);
  localparam op_t OP_STO  = op_t'(1);
  localparam op_t OP_LD   = op_t'(2);
  localparam op_t OP_LDI  = op_t'(3);
  localparam op_t OP_ADD  = op_t'(4);
  localparam op_t OP_ADDI = op_t'(5);
  localparam op_t OP_SUB  = op_t'(6);
  localparam op_t OP_SUBI = op_t'(7);
  localparam op_t OP_BEQ  = op_t'(8);
  localparam op_t OP_BNE  = op_t'(9);
`ifdef CTRL_EXT_BRANCH_EN
  localparam op_t OP_BGT  = op_t'(10);
  localparam op_t OP_BGE  = op_t'(11);
  localparam op_t OP_BLT  = op_t'(12);
  localparam op_t OP_BLE  = op_t'(13);
`endif
  localparam op_t OP_JMP  = op_t'(14);

  typedef enum logic [2:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_HALT
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [IW-1:0]         ir_q, ir_d;
  op_t                   opcode;
  logic                  taken;

  assign opcode = ir_q[IW-1:DATA_WIDTH];
  assign program_memory_address_out = pc_q;
  assign operand_out = ir_q[DATA_WIDTH-1:0];

`ifndef CTRL_EXT_BRANCH_EN
  logic unused_flag_n;
  assign unused_flag_n = flag_N_in;
`endif

  // State, PC and IR registers; reset aborts any instruction in flight.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q <= S_RESET;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next state, next PC and strobes; flags only reach the next-PC path.
  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    ir_d               = ir_q;
    taken              = 1'b0;
    op_alu_out         = 1'b0;
    sel_A_out          = 2'b00;
    sel_B_out          = 1'b0;
    acc_wr_out         = 1'b0;
    acc_reset_out      = 1'b0;
    status_wr_out      = 1'b0;
    status_reset_out   = 1'b0;
    data_memory_wr_out = 1'b0;
    halted_out         = 1'b0;
    case (state_q)
      S_RESET: begin
        acc_reset_out    = 1'b1;
        status_reset_out = 1'b1;
        state_d          = S_FETCH;
      end
      S_FETCH: begin
        ir_d    = instruction_in;
        pc_d    = pc_q + 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        state_d = S_FETCH;
        case (opcode)
          OP_HLT:  state_d = S_HALT;
          OP_STO:  data_memory_wr_out = 1'b1;
          OP_LD: begin
            sel_A_out  = 2'b01;
            acc_wr_out = 1'b1;
          end
          OP_LDI: begin
            sel_A_out  = 2'b10;
            acc_wr_out = 1'b1;
          end
          OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
            sel_B_out     = opcode[0];
            op_alu_out    = opcode[1];
            acc_wr_out    = 1'b1;
            status_wr_out = 1'b1;
          end
          OP_BEQ:  taken = flag_Z_in;
          OP_BNE:  taken = !flag_Z_in;
`ifdef CTRL_EXT_BRANCH_EN
          OP_BGT:  taken = !flag_Z_in && !flag_N_in;
          OP_BGE:  taken = !flag_N_in;
          OP_BLT:  taken = flag_N_in;
          OP_BLE:  taken = flag_N_in || flag_Z_in;
`endif
          OP_JMP:  taken = 1'b1;
          default: ;
        endcase
        if (taken) pc_d = ir_q[DATA_WIDTH-1:0];
      end
      S_HALT: begin
        halted_out = 1'b1;
      end
      default: state_d = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: instruction-level model plus directed programs for control_unit.
// Checks every negedge against the model and pins key points with literals.
module tb_control_unit;

  logic        clock_in = 1'b0;
  logic        reset_n_in = 1'b1;
  logic [15:0] instruction_in;
  logic        flag_Z_in, flag_N_in;
  logic [10:0] program_memory_address_out, operand_out;
  logic        op_alu_out, sel_B_out, acc_wr_out, acc_reset_out;
  logic [1:0]  sel_A_out;
  logic        status_wr_out, status_reset_out, data_memory_wr_out, halted_out;

  control_unit dut (
    .clock_in                   (clock_in),
    .reset_n_in                 (reset_n_in),
    .instruction_in             (instruction_in),
    .flag_Z_in                  (flag_Z_in),
    .flag_N_in                  (flag_N_in),
    .program_memory_address_out (program_memory_address_out),
    .operand_out                (operand_out),
    .op_alu_out                 (op_alu_out),
    .sel_A_out                  (sel_A_out),
    .sel_B_out                  (sel_B_out),
    .acc_wr_out                 (acc_wr_out),
    .acc_reset_out              (acc_reset_out),
    .status_wr_out              (status_wr_out),
    .status_reset_out           (status_reset_out),
    .data_memory_wr_out         (data_memory_wr_out),
    .halted_out                 (halted_out)
  );

  always #5 clock_in = ~clock_in;

  logic [15:0] pmem [0:2047];
  logic        fz   [0:2047];
  logic        fn   [0:2047];

  assign instruction_in = pmem[program_memory_address_out];
  assign flag_Z_in      = fz[program_memory_address_out];
  assign flag_N_in      = fn[program_memory_address_out];

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // {op_alu, sel_A[1:0], sel_B, acc_wr, status_wr, dm_wr}
  function automatic logic [6:0] strobes(input logic [4:0] op);
    case (op)
      5'd1:    return 7'b0_00_0_0_0_1;
      5'd2:    return 7'b0_01_0_1_0_0;
      5'd3:    return 7'b0_10_0_1_0_0;
      5'd4:    return 7'b0_00_0_1_1_0;
      5'd5:    return 7'b0_00_1_1_1_0;
      5'd6:    return 7'b1_00_0_1_1_0;
      5'd7:    return 7'b1_00_1_1_1_0;
      default: return 7'b0;
    endcase
  endfunction

  function automatic bit br_taken(input logic [4:0] op, input logic z,
                                  input logic n);
    case (op)
      5'd8:    return z;
      5'd9:    return !z;
`ifdef CTRL_EXT_BRANCH_EN
      5'd10:   return !z && !n;
      5'd11:   return !n;
      5'd12:   return n;
      5'd13:   return n || z;
`endif
      5'd14:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Model: phase within an instruction (0 reset, 1..3 fetch/decode/exec, 4 halted).
  int          m_ph = 0;
  logic [10:0] m_pc = '0;
  logic [15:0] m_ir = '0;

  always @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      m_ph = 0;
      m_pc = '0;
      m_ir = '0;
    end else begin
      case (m_ph)
        0: m_ph = 1;
        1: begin
          m_ir = pmem[m_pc];
          m_pc = m_pc + 11'd1;
          m_ph = 2;
        end
        2: m_ph = 3;
        3: begin
          if (m_ir[15:11] == 5'd0) m_ph = 4;
          else begin
            if (br_taken(m_ir[15:11], flag_Z_in, flag_N_in))
              m_pc = m_ir[10:0];
            m_ph = 1;
          end
        end
        default: ;
      endcase
    end
  end

  logic [9:0] act_ctl, exp_ctl;
  assign act_ctl = {op_alu_out, sel_A_out, sel_B_out, acc_wr_out,
                    status_wr_out, data_memory_wr_out, acc_reset_out,
                    status_reset_out, halted_out};

  // Compare all outputs to the model on every falling edge.
  always @(negedge clock_in) begin
    if (chk_en) begin
      exp_ctl = {(m_ph == 3) ? strobes(m_ir[15:11]) : 7'b0,
                 m_ph == 0, m_ph == 0, m_ph == 4};
      chk("pc", program_memory_address_out, m_pc);
      chk("operand", operand_out, m_ir[10:0]);
      chk("ctl", act_ctl, exp_ctl);
    end
  end

  task automatic adv(input int k);
    repeat (k) @(negedge clock_in);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) begin
      pmem[i] = 16'h7800;
      fz[i]   = 1'b0;
      fn[i]   = 1'b0;
    end
  endtask

  initial begin
    clear_mem();
    pmem[0]     = 16'h1805;
    pmem[1]     = 16'h2803;
    pmem[2]     = 16'h3803;
    pmem[3]     = 16'h4100;
    fz[4]       = 1'b1;
    pmem[11'h100] = 16'h4200;
    pmem[11'h101] = 16'h6020;
    fn[11'h102]   = 1'b1;
    pmem[11'h020] = 16'h77FF;
    pmem[11'h102] = 16'h77FF;
    pmem[11'h7FF] = 16'h7800;

    #3 reset_n_in = 1'b0;
    @(negedge clock_in);
    chk_en = 1'b1;
    adv(1);
    #2 reset_n_in = 1'b1;
    chk("rst_strobes", {acc_reset_out, status_reset_out}, 2'b11);
    adv(1);
    chk("rst_drop", {acc_reset_out, status_reset_out}, 2'b00);
    adv(2);
    chk("ldi_exec", {sel_A_out, acc_wr_out, operand_out}, {2'b10, 1'b1, 11'd5});
    adv(1);
    chk("ldi_pc", program_memory_address_out, 11'd1);
    adv(1);
    chk("decode_idle", {op_alu_out, sel_A_out, sel_B_out, acc_wr_out,
                        status_wr_out, data_memory_wr_out}, 7'b0);
    adv(1);
    chk("addi_exec", {op_alu_out, sel_B_out, acc_wr_out, status_wr_out}, 4'b0111);
    adv(3);
    chk("subi_exec", {op_alu_out, sel_B_out, acc_wr_out, status_wr_out}, 4'b1111);
    adv(4);
    chk("beq_taken", program_memory_address_out, 11'h100);
    adv(3);
    chk("beq_not_taken", program_memory_address_out, 11'h101);
    adv(2);
    chk("blt_no_strobe", {op_alu_out, sel_A_out, sel_B_out, acc_wr_out,
                          status_wr_out, data_memory_wr_out}, 7'b0);
    adv(1);
`ifdef CTRL_EXT_BRANCH_EN
    chk("blt_pc", program_memory_address_out, 11'h020);
`else
    chk("blt_pc", program_memory_address_out, 11'h102);
`endif
    adv(3);
    chk("jmp_7ff", program_memory_address_out, 11'h7FF);
    adv(1);
    chk("pc_wrap", program_memory_address_out, 11'h000);

    #2 reset_n_in = 1'b0;
    clear_mem();
    pmem[0] = 16'h2010;
    pmem[1] = 16'h3011;
    pmem[2] = 16'h1005;
    pmem[3] = 16'h0806;
    pmem[4] = 16'h4809;
    pmem[9] = 16'h0000;
    adv(2);
    #2 reset_n_in = 1'b1;
    adv(3);
    chk("add_exec", {acc_wr_out, status_wr_out}, 2'b11);
    #2 reset_n_in = 1'b0;
    #1;
    chk("abort_strobes", {acc_wr_out, status_wr_out, acc_reset_out,
                          status_reset_out}, 4'b0011);
    chk("abort_pc", program_memory_address_out, 11'd0);
    adv(2);
    #2 reset_n_in = 1'b1;
    adv(19);
    chk("halt_entry", {halted_out, program_memory_address_out}, {1'b1, 11'd10});
    for (int i = 0; i < 10; i++) begin
      adv(1);
      chk("halt_hold", {halted_out, program_memory_address_out, op_alu_out,
                        sel_A_out, sel_B_out, acc_wr_out, status_wr_out,
                        data_memory_wr_out},
          {1'b1, 11'd10, 7'b0});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Multicycle controller that drives the accumulator datapath of the 11-bit processor. It fetches 16-bit instructions from program memory and decodes them into the datapath control strobes. It uses the datapath's Z/N status flags to resolve conditional branches. It is the counterpart of the datapath: the datapath consumes every control output here, and this block consumes the datapath's flags.

## Interface
- DATA_WIDTH, 11, operand, program counter and address width
- OPCODE_WIDTH, 5, opcode field width; instruction width = OPCODE_WIDTH + DATA_WIDTH
- clock_in  in  1  system clock, rising edge
- reset_n_in  in  1  asynchronous, active-low reset
- instruction_in  in  16  program memory word; combinational read of program_memory_address_out; opcode = [15:11], operand = [10:0]
- flag_Z_in, flag_N_in  in  1 each  datapath status register outputs
- program_memory_address_out  out  11  program counter
- operand_out  out  11  operand field of the instruction register
- op_alu_out  out  1  ALU operation: 0 = add, 1 = sub
- sel_A_out  out  2  accumulator source: 00 = ALU, 01 = data memory, 10 = operand
- sel_B_out  out  1  ALU B operand: 0 = data memory, 1 = operand
- acc_wr_out, acc_reset_out, status_wr_out, status_reset_out  out  1 each  datapath strobes
- data_memory_wr_out  out  1  data memory write enable (writes the accumulator to operand_out)
- halted_out  out  1  high in the HALT state

## Operation
- State register holds RESET, FETCH, DECODE, EXECUTE or HALT.
- Transitions: RESET→FETCH, FETCH→DECODE, DECODE→EXECUTE, EXECUTE→FETCH. EXECUTE goes to HALT instead when the opcode is HLT. HALT→HALT until reset.
- RESET asserts acc_reset_out and status_reset_out. All other strobes are 0.
- FETCH: IR ← instruction_in; PC ← PC+1, wrapping 2047→0.
- DECODE: no strobes. operand_out is stable, so the synchronous data memory read completes.
- EXECUTE drives exactly one instruction's strobes, for one cycle:
  - 00000 HLT: none.
  - 00001 STO: data_memory_wr_out.
  - 00010 LD: sel_A=01, acc_wr.
  - 00011 LDI: sel_A=10, acc_wr.
  - 00100 ADD: sel_B=0, op_alu=0, sel_A=00, acc_wr, status_wr.
  - 00101 ADDI: as ADD with sel_B=1.
  - 00110 SUB: as ADD with op_alu=1.
  - 00111 SUBI: sel_B=1, op_alu=1, sel_A=00, acc_wr, status_wr.
  - 01000 BEQ (Z=1), 01001 BNE (Z=0): PC ← operand when the condition is true.
  - 01010 BGT (!Z&!N), 01011 BGE (!N), 01100 BLT (N), 01101 BLE (N|Z): PC ← operand when the condition is true.
  - 01110 JMP: PC ← operand unconditionally.
  - 01111–11111: NOP.
- Idle strobe values outside EXECUTE: op_alu, sel_A and sel_B hold 0.
- Branches sample the flags in EXECUTE. Flags written by the previous instruction's EXECUTE are already visible.
- A branch target of 0 or 2047 is legal. PC wraps silently.

## Timing
- Reset (asynchronous, reset_n_in low):
  - State = RESET, PC = 0, IR = 0.
  - program_memory_address_out = 0, operand_out = 0, halted_out = 0.
  - acc_reset_out = 1, status_reset_out = 1 while reset is held. All other outputs are 0.
- First rising edge after reset release: RESET→FETCH. The reset strobes drop after that edge.
- Every instruction takes 3 cycles. EXECUTE strobes are asserted for exactly one cycle and take effect in the datapath on the edge that leaves EXECUTE.
- A taken branch updates PC on that same edge. The next FETCH reads the target.
- Reset asserted mid-instruction aborts it immediately. No strobe remains asserted except the reset strobes.
- All outputs are registered or decoded from state and IR only. No combinational path exists from flag_Z_in or flag_N_in to any output other than the next-PC logic.

## Configuration
- CTRL_EXT_BRANCH_EN:
  - Defined: BGT, BGE, BLT and BLE are implemented as specified above.
  - Undefined: opcodes 01010–01101 decode as NOP. PC advances normally, and the decoder has no N-flag logic. BEQ, BNE and JMP are unaffected.

## Test plan
- Reset and LDI:
  - Stimulus: hold reset_n_in low, release it; instruction 0 = LDI 5 (0x1805).
  - Required: acc_reset_out and status_reset_out high until the first edge after release.
  - Required: in EXECUTE (cycle 3 after FETCH), sel_A_out=10, acc_wr_out=1, operand_out=5; PC=1 afterwards.
- ADDI then SUBI:
  - Stimulus: ADDI 3, then SUBI 3.
  - Required: ADDI EXECUTE drives op_alu=0, sel_B=1, acc_wr=1, status_wr=1.
  - Required: SUBI EXECUTE drives op_alu=1 with the same strobes.
  - Required: no strobes in FETCH or DECODE.
- Branches:
  - Stimulus: BEQ 0x100 with flag_Z_in=1.
  - Required: next program_memory_address_out = 0x100.
  - Stimulus: same instruction with flag_Z_in=0.
  - Required: next address = old PC+1.
- Extended branches:
  - Stimulus: with CTRL_EXT_BRANCH_EN, BLT 0x20 with N=1.
  - Required: jumps to 0x20.
  - Stimulus: same instruction without the macro.
  - Required: PC+1, no strobes.
- Halt and wrap:
  - Stimulus: HLT.
  - Required: halted_out=1, PC frozen for 10 cycles, no strobes.
  - Stimulus: JMP 2047 followed by a NOP at 2047.
  - Required: PC wraps to 0.
- Mid-instruction reset:
  - Stimulus: assert reset_n_in in the EXECUTE cycle of ADD.
  - Required: acc_wr_out and status_wr_out drop immediately; PC=0, state RESET.
